// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial-pattern detector:
// state encoding, reset-time default pattern and fill-counter sizing.
package seq_det_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam logic [3:0] DEFAULT_PAT = 4'b1011;

    // Width of a counter that must hold 0..pat_w-1; never narrower than 1 bit.
    function automatic int fill_w(input int pat_w);
        return (pat_w <= 2) ? 1 : $clog2(pat_w);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with sticky saturation flag; clear has priority over increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
            if (count == CNT_MAX - CNT_W'(1)) begin
                sat <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Mealy serial-pattern detector with run-time loadable pattern, overlap control,
// valid-qualified input, registered match pulse and saturating match counter.
module seq_detector_param #(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(seq_det_pkg::DEFAULT_PAT),
    parameter int               CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             din,
    input  logic [PAT_W-1:0] pattern,
    input  logic             pattern_load,
    input  logic             overlap_en,
    input  logic             count_clr,
    output logic             dout,
    output logic             match_q,
    output logic [CNT_W-1:0] match_count,
    output logic             cnt_sat
);

    import seq_det_pkg::*;

    localparam int FILL_W = fill_w(PAT_W);

    typedef logic [PAT_W-2:0] hist_t;

    state_t            state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    hist_t             hist_q, hist_d;
    logic [PAT_W-1:0]  pat_reg;
    logic              match;

    // The window is the held history plus the bit on the wire this cycle.
    assign match = (state_q == ARMED) && ({hist_q, din} == pat_reg);
    assign dout  = din_valid && !pattern_load && match;

    // NOTE: every variable gets a hold default before any branch, so no latches are inferred.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        hist_d  = hist_q;
        if (pattern_load) begin
            state_d = FILL;
            fill_d  = '0;
            hist_d  = '0;
        end else if (din_valid) begin
            hist_d = hist_t'({hist_q, din});
            case (state_q)
                FILL: begin
                    fill_d = fill_q + FILL_W'(1);
                    if (fill_q == FILL_W'(PAT_W - 2)) begin
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    if (match && !overlap_en) begin
                        state_d = FILL;
                        fill_d  = '0;
                    end
                end
                default: begin
                    state_d = FILL;
                    fill_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            fill_q  <= '0;
            hist_q  <= '0;
            pat_reg <= DEFAULT_PAT;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            hist_q  <= hist_d;
            match_q <= dout;
            if (pattern_load) begin
                pat_reg <= pattern;
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (dout),
        .clr   (count_clr),
        .count (match_count),
        .sat   (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: expected dout/match_q values are queued
// as each bit is driven and compared when the DUT presents them.
module tb_seq_detector_param;

    localparam int PAT_W = 4;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             din_valid;
    logic             din;
    logic [PAT_W-1:0] pattern;
    logic             pattern_load;
    logic             overlap_en;
    logic             count_clr;
    logic             dout;
    logic             match_q;
    logic [CNT_W-1:0] match_count;
    logic             cnt_sat;

    int n_checks = 0;
    int n_fail   = 0;

    logic q_dout[$];
    logic q_mq[$];

    seq_detector_param #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .din_valid    (din_valid),
        .din          (din),
        .pattern      (pattern),
        .pattern_load (pattern_load),
        .overlap_en   (overlap_en),
        .count_clr    (count_clr),
        .dout         (dout),
        .match_q      (match_q),
        .match_count  (match_count),
        .cnt_sat      (cnt_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // dout is combinational: compare mid-low-phase, after inputs settle and before the edge.
    always @(negedge clk) begin
        #3;
        if (q_dout.size() > 0) check("dout", dout, q_dout.pop_front());
    end

    // match_q shows the previous cycle's dout just after the rising edge.
    always @(posedge clk) begin
        #1;
        if (q_mq.size() > 0) check("match_q", match_q, q_mq.pop_front());
    end

    task automatic drive(input logic v, input logic d, input logic exp);
        @(negedge clk);
        din_valid = v;
        din       = d;
        q_dout.push_back(exp);
        q_mq.push_back(exp);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    // Sends n bits, MSB first, with the matching expected-dout bits.
    task automatic send(input logic [15:0] bits, input logic [15:0] exp, input int n);
        for (int i = n - 1; i >= 0; i--) drive(1'b1, bits[i], exp[i]);
    endtask

    task automatic load(input logic [PAT_W-1:0] p);
        @(negedge clk);
        pattern      = p;
        pattern_load = 1'b1;
        din_valid    = 1'b1;
        din          = 1'($urandom_range(1, 0));
        q_dout.push_back(1'b0);
        q_mq.push_back(1'b0);
        @(posedge clk);
        #1;
        pattern_load = 1'b0;
        din_valid    = 1'b0;
    endtask

    task automatic clear_count();
        @(negedge clk);
        count_clr = 1'b1;
        @(posedge clk);
        #1;
        count_clr = 1'b0;
        check("clr_count", match_count, 0);
        check("clr_sat", cnt_sat, 0);
    endtask

    initial begin
        rst          = 1'b0;
        din_valid    = 1'b0;
        din          = 1'b0;
        pattern      = '0;
        pattern_load = 1'b0;
        overlap_en   = 1'b1;
        count_clr    = 1'b0;

        #1;
        check("rst_dout", dout, 0);
        check("rst_match_q", match_q, 0);
        check("rst_count", match_count, 0);
        check("rst_sat", cnt_sat, 0);
        @(negedge clk);
        rst = 1'b1;

        // Overlapping detection of 1011 in 1011011.
        send(16'b1011011, 16'b0001001, 7);
        check("ovl_count", match_count, 2);

        // Non-overlapping: second occurrence shares a bit, so it is not reported.
        load(4'b1011);
        clear_count();
        overlap_en = 1'b0;
        send(16'b1011011, 16'b0001000, 7);
        check("novl_count", match_count, 1);
        overlap_en = 1'b1;

        // Valid gaps with random din between the real bits.
        load(4'b1011);
        clear_count();
        for (int i = 3; i >= 0; i--) begin
            logic [3:0] bits;
            bits = 4'b1011;
            drive(1'b1, bits[i], (i == 0));
            if (i != 0) begin
                repeat (2) drive(1'b0, 1'($urandom_range(1, 0)), 1'b0);
            end
        end
        check("gap_count", match_count, 1);

        // Load 0110 after 1,0,1; the coincident 1 must be discarded.
        load(4'b1011);
        send(16'b101, 16'b000, 3);
        @(negedge clk);
        pattern      = 4'b0110;
        pattern_load = 1'b1;
        din_valid    = 1'b1;
        din          = 1'b1;
        q_dout.push_back(1'b0);
        q_mq.push_back(1'b0);
        @(posedge clk);
        #1;
        pattern_load = 1'b0;
        din_valid    = 1'b0;
        check("load_keeps_count", match_count, 1);
        send(16'b0110, 16'b0001, 4);
        check("load_count", match_count, 2);

        // Async reset between edges while a valid bit is presented.
        send(16'b101, 16'b000, 3);
        @(negedge clk);
        din_valid = 1'b1;
        din       = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("arst_dout", dout, 0);
        check("arst_match_q", match_q, 0);
        check("arst_count", match_count, 0);
        check("arst_sat", cnt_sat, 0);
        @(negedge clk);
        din_valid = 1'b0;
        rst       = 1'b1;
        send(16'b11, 16'b00, 2);
        send(16'b1011, 16'b0001, 4);
        check("post_rst_count", match_count, 1);

        // Saturation with a 2-bit counter.
        load(4'b1011);
        clear_count();
        send(16'b1011011, 16'b0001001, 7);
        check("sat2_count", match_count, 2);
        check("sat2_flag", cnt_sat, 0);
        send(16'b011, 16'b001, 3);
        check("sat3_count", match_count, 3);
        check("sat3_flag", cnt_sat, 1);
        send(16'b011011, 16'b001001, 6);
        check("sat5_count", match_count, 3);
        check("sat5_flag", cnt_sat, 1);

        // Clear coincident with a match: clear wins.
        for (int k = 0; k < 2; k++) begin
            send(16'b01, 16'b00, 2);
            count_clr = 1'b1;
            drive(1'b1, 1'b1, 1'b1);
            count_clr = 1'b0;
            check("clr_win_count", match_count, 0);
            check("clr_win_sat", cnt_sat, 0);
        end
        send(16'b011, 16'b001, 3);
        check("after_clr_count", match_count, 1);

        repeat (2) @(negedge clk);
        check("dout_q_drained", q_dout.size(), 0);
        check("mq_q_drained", q_mq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
